// File: rtl/roe_pkg.sv
// Shared constants and types for the R.O.E datapath (decoder, register file, ALU).
package roe_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int REG_CNT = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage : roe_pkg

// File: rtl/reg_read_port.sv
// One combinational read port: register select mux plus optional same-cycle
// write forwarding. Instantiated once per read port so both behave identically.
module reg_read_port #(
  parameter int DATA_W = roe_pkg::DATA_W,
  parameter int ADDR_W = roe_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                raddr,
  input  logic                             fwd_en,
  input  logic [ADDR_W-1:0]                waddr,
  input  logic [DATA_W-1:0]                wdata,
  output logic [DATA_W-1:0]                rdata
);

  // Select the stored value, overridden by the in-flight write when forwarding is on.
  // NOTE: rdata is assigned first on every path, so no latch is inferred.
  always_comb begin
    rdata = regs[raddr];
    if ((BYPASS != 0) && fwd_en && (waddr == raddr)) begin
      rdata = wdata;
    end
  end

endmodule : reg_read_port

// File: rtl/reg_file.sv
// 16 x 8 register file with two combinational read ports, one synchronous
// write port and a carry flag. Reset clears every entry and the carry flag.
module reg_file #(
  parameter int DATA_W = roe_pkg::DATA_W,
  parameter int ADDR_W = roe_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              carry_we,
  input  logic              carry_in,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              carry_out
);

  localparam int REG_CNT = 2 ** ADDR_W;

  logic [REG_CNT-1:0][DATA_W-1:0] regs;
  logic                           carry;
  logic                           fwd_en;

  // Register array: cleared by reset, one entry written per rising edge.
  // NOTE: the array is reset here because reads must show 0 after reset;
  // sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  // Carry flag: updated independently of the register write enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry <= 1'b0;
    end else if (carry_we) begin
      carry <= carry_in;
    end
  end

  // A write held off by reset must not be forwarded either.
  assign fwd_en    = we & ~reset;
  assign carry_out = carry;

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port_a (
    .regs   (regs),
    .raddr  (raddr_a),
    .fwd_en (fwd_en),
    .waddr  (waddr),
    .wdata  (wdata),
    .rdata  (rdata_a)
  );

  reg_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port_b (
    .regs   (regs),
    .raddr  (raddr_b),
    .fwd_en (fwd_en),
    .waddr  (waddr),
    .wdata  (wdata),
    .rdata  (rdata_b)
  );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file. Two instances (forwarding on and off) share
// the same stimulus; a reference model of the register contents predicts
// each cycle's read data, which a monitor compares mid-cycle.
module tb_reg_file;
  import roe_pkg::*;

  logic      clk;
  logic      reset;
  reg_addr_t raddr_a, raddr_b, waddr;
  logic      we, carry_we, carry_in;
  data_t     wdata;
  data_t     rdata_a_fw, rdata_b_fw, rdata_a_nf, rdata_b_nf;
  logic      carry_out_fw, carry_out_nf;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string tag;
    data_t a_fw;
    data_t b_fw;
    data_t a_nf;
    data_t b_nf;
    logic  carry;
  } exp_t;

  exp_t  sb_q[$];
  data_t model_regs [REG_CNT];
  logic  model_carry;

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1)) dut_fw (
    .clk       (clk),
    .reset     (reset),
    .raddr_a   (raddr_a),
    .raddr_b   (raddr_b),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .carry_we  (carry_we),
    .carry_in  (carry_in),
    .rdata_a   (rdata_a_fw),
    .rdata_b   (rdata_b_fw),
    .carry_out (carry_out_fw)
  );

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(0)) dut_nf (
    .clk       (clk),
    .reset     (reset),
    .raddr_a   (raddr_a),
    .raddr_b   (raddr_b),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .carry_we  (carry_we),
    .carry_in  (carry_in),
    .rdata_a   (rdata_a_nf),
    .rdata_b   (rdata_b_nf),
    .carry_out (carry_out_nf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < REG_CNT; i++) model_regs[i] = '0;
    model_carry = 1'b0;
  endtask

  // Drive one cycle just after the rising edge, predict what both instances
  // show before the next edge, then commit the write into the model.
  task automatic cyc(input string tag, input logic rst_v, input logic we_v,
                     input reg_addr_t wa, input data_t wd,
                     input reg_addr_t ra, input reg_addr_t rb,
                     input logic cwe, input logic cin);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rst_v;
    we       = we_v;
    waddr    = wa;
    wdata    = wd;
    raddr_a  = ra;
    raddr_b  = rb;
    carry_we = cwe;
    carry_in = cin;
    if (rst_v) model_clear();
    e.tag   = tag;
    e.a_nf  = model_regs[ra];
    e.b_nf  = model_regs[rb];
    e.a_fw  = (!rst_v && we_v && wa == ra) ? wd : model_regs[ra];
    e.b_fw  = (!rst_v && we_v && wa == rb) ? wd : model_regs[rb];
    e.carry = model_carry;
    sb_q.push_back(e);
    if (!rst_v) begin
      if (we_v) model_regs[wa] = wd;
      if (cwe)  model_carry = cin;
    end
  endtask

  // Monitor: combinational outputs are valid every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.tag, ".a_fw"},  32'(rdata_a_fw),   32'(e.a_fw));
        check({e.tag, ".b_fw"},  32'(rdata_b_fw),   32'(e.b_fw));
        check({e.tag, ".a_nf"},  32'(rdata_a_nf),   32'(e.a_nf));
        check({e.tag, ".b_nf"},  32'(rdata_b_nf),   32'(e.b_nf));
        check({e.tag, ".c_fw"},  32'(carry_out_fw), 32'(e.carry));
        check({e.tag, ".c_nf"},  32'(carry_out_nf), 32'(e.carry));
      end
    end
  end

  initial begin
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr_a = '0; raddr_b = '0; carry_we = 1'b0; carry_in = 1'b0;
    model_clear();

    // Reset state
    cyc("rst_hold", 1'b1, 1'b0, 4'd0, 8'h00, 4'd0, 4'd15, 1'b0, 1'b0);
    cyc("rst_rel",  1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 4'd12, 1'b0, 1'b0);

    // Write then read
    cyc("wr3",   1'b0, 1'b1, 4'd3, 8'h3C, 4'd0, 4'd1, 1'b0, 1'b0);
    cyc("rd3_4", 1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 4'd4, 1'b0, 1'b0);

    // Same-cycle forwarding: r7 = 11, then overwrite with 99 while reading r7
    cyc("wr7",     1'b0, 1'b1, 4'd7, 8'h11, 4'd0, 4'd0, 1'b0, 1'b0);
    cyc("byp7",    1'b0, 1'b1, 4'd7, 8'h99, 4'd7, 4'd7, 1'b0, 1'b0);
    cyc("after7",  1'b0, 1'b0, 4'd0, 8'h00, 4'd7, 4'd7, 1'b0, 1'b0);

    // Carry and register updated on the same edge; carry then holds
    cyc("cy_wr",   1'b0, 1'b1, 4'd15, 8'hFF, 4'd15, 4'd3, 1'b1, 1'b1);
    cyc("cy_hold", 1'b0, 1'b0, 4'd0,  8'h00, 4'd15, 4'd7, 1'b0, 1'b0);
    cyc("cy_hld2", 1'b0, 1'b0, 4'd0,  8'h00, 4'd15, 4'd15, 1'b0, 1'b0);

    // Full sweep, then read all pairs (i, 15-i)
    for (int i = 0; i < REG_CNT; i++)
      cyc("sweep_wr", 1'b0, 1'b1, reg_addr_t'(i), data_t'(8'hF0 + i), 4'd0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < REG_CNT; i++)
      cyc("sweep_rd", 1'b0, 1'b0, 4'd0, 8'h00, reg_addr_t'(i), reg_addr_t'(15 - i), 1'b0, 1'b0);

    // Decoder hookup: set_pa=3'b110, lower_reg_addr=2'b01 yields reg_addr 4'b1001
    cyc("dec_wr9", 1'b0, 1'b1, 4'd9, 8'h5A, 4'd0, 4'd0, 1'b0, 1'b0);
    cyc("dec_rd9", 1'b0, 1'b0, 4'd0, 8'h00, 4'b1001, 4'd8, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle after r5 = A5 with carry set
    cyc("wr5",  1'b0, 1'b1, 4'd5, 8'hA5, 4'd0, 4'd0, 1'b1, 1'b1);
    cyc("rd5",  1'b0, 1'b0, 4'd0, 8'h00, 4'd5, 4'd5, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    check("pre_async.a_fw", 32'(rdata_a_fw), 32'h0000_00A5);
    reset = 1'b1;
    #1;
    check("async_rst.a_fw", 32'(rdata_a_fw),   32'h0);
    check("async_rst.b_nf", 32'(rdata_b_nf),   32'h0);
    check("async_rst.c_fw", 32'(carry_out_fw), 32'h0);
    check("async_rst.c_nf", 32'(carry_out_nf), 32'h0);
    model_clear();

    // Writes ignored during reset; first write lands after release
    cyc("rst_wr",   1'b1, 1'b1, 4'd5, 8'h77, 4'd5, 4'd5, 1'b1, 1'b1);
    cyc("rel_rd",   1'b0, 1'b1, 4'd6, 8'h66, 4'd5, 4'd6, 1'b0, 1'b0);
    cyc("rel_rd6",  1'b0, 1'b0, 4'd0, 8'h00, 4'd6, 4'd9, 1'b0, 1'b0);

    // Randomized traffic, occasionally aiming reads at the write address
    for (int n = 0; n < 400; n++) begin
      logic      r_rst, r_we, r_cwe, r_cin;
      reg_addr_t r_wa, r_ra, r_rb;
      data_t     r_wd;
      r_rst = ($urandom_range(0, 49) == 0);
      r_we  = $urandom_range(0, 1) == 1;
      r_cwe = $urandom_range(0, 3) == 0;
      r_cin = $urandom_range(0, 1) == 1;
      r_wa  = reg_addr_t'($urandom_range(0, REG_CNT - 1));
      r_wd  = data_t'($urandom_range(0, 255));
      r_ra  = ($urandom_range(0, 3) == 0) ? r_wa : reg_addr_t'($urandom_range(0, REG_CNT - 1));
      r_rb  = ($urandom_range(0, 3) == 0) ? r_wa : reg_addr_t'($urandom_range(0, REG_CNT - 1));
      cyc("rand", r_rst, r_we, r_wa, r_wd, r_ra, r_rb, r_cwe, r_cin);
    end

    // Let the monitor consume the last expectation
    @(posedge clk);
    #1;
    we = 1'b0;
    carry_we = 1'b0;
    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_file
